// File: rtl/gcd_8_ctrl.sv
// Subtractive-Euclid GCD controller: owns the operand registers, drives the
// operand-mux select, and strobes done for one cycle when the result is ready.
module gcd_8_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ld_sel
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;

   logic             a_gt_b;
   logic             finish;
   logic [WIDTH-1:0] diff_ab;
   logic [WIDTH-1:0] diff_ba;
   logic [WIDTH-1:0] a_mux;
   logic [WIDTH-1:0] b_mux;

   // Only the larger operand is reduced, so neither difference can wrap.
   assign a_gt_b  = (a_q > b_q);
   assign finish  = (a_q == '0) || (b_q == '0) || (a_q == b_q);
   assign diff_ab = a_q - b_q;
   assign diff_ba = b_q - a_q;

   assign a_mux = ld_sel ? a_in : (a_gt_b ? diff_ab : a_q);
   assign b_mux = ld_sel ? b_in : (a_gt_b ? b_q : diff_ba);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a_mux;
               b_d     = b_mux;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (finish) begin
               res_d   = a_q | b_q;
               state_d = S_DONE;
            end else begin
               a_d = a_mux;
               b_d = b_mux;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs: decoded from the state register only.
   assign busy   = (state_q == S_RUN);
   assign done   = (state_q == S_DONE);
   assign ld_sel = (state_q != S_RUN);
   assign result = res_q;

endmodule

// File: tb/tb_gcd_8_ctrl.sv
// Directed + randomized bench for gcd_8_ctrl against a modulo-Euclid reference.
module tb_gcd_8_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic       busy, done, ld_sel;
   logic [7:0] result;

   int tests = 0;
   int fails = 0;
   logic [15:0] trace[$];
   int last_cycles;
   int last_busy;

   gcd_8_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .result(result), .ld_sel(ld_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: gcd by modulo Euclid; subtraction count is the sum of the
   // quotients minus one (the last quotient stops one short at x==y).
   task automatic ref_gcd(input int a, input int b, output int g, output int s);
      int x, y, q, r;
      if (a == 0 || b == 0) begin
         g = a | b;
         s = 0;
      end else begin
         x = (a > b) ? a : b;
         y = (a > b) ? b : a;
         s = 0;
         while (y != 0) begin
            q = x / y;
            r = x % y;
            s += q;
            x = y;
            y = r;
         end
         g = x;
         s -= 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after an edge with the DUT idle. Operands are scrambled after
   // acceptance; optionally a stray start pulse is injected at cycle inj.
   task automatic do_op(input int a, input int b, input string tag, input int inj);
      int g, s, cyc, bcnt;
      logic [7:0] prev_res;
      bit seen;
      ref_gcd(a, b, g, s);
      trace.delete();
      prev_res = result;
      a_in = 8'(a);
      b_in = 8'(b);
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      bcnt = 0;
      seen = 0;
      if (busy) bcnt++;
      trace.push_back({dut.a_q, dut.b_q});
      while (cyc < 300 && !seen) begin
         a_in = 8'($urandom);
         b_in = 8'($urandom);
         start = (cyc == inj) ? 1'b1 : 1'b0;
         if (cyc == inj) begin
            a_in = 8'd9;
            b_in = 8'd3;
         end
         tick();
         start = 1'b0;
         cyc++;
         if (done) seen = 1;
         else begin
            if (busy) bcnt++;
            trace.push_back({dut.a_q, dut.b_q});
            if (result !== prev_res || ld_sel !== 1'b0) check({tag, "_run_hold"}, {result, 7'd0, ld_sel}, {prev_res, 8'd0});
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_cycles"}, 32'(cyc), 32'(s + 1));
      check({tag, "_result"}, 32'(result), 32'(g));
      check({tag, "_done_outs"}, {30'd0, busy, ld_sel}, 32'd1);
      tick();
      check({tag, "_done_1cyc"}, {30'd0, done, busy}, 32'd0);
      last_cycles = cyc;
      last_busy = bcnt;
   endtask

   initial begin
      int t_done[$];
      int t_busy_rise[$];
      logic pb;
      int ra, rb;
      bit bad_done;

      // Reset state
      #1;
      check("rst_outs", {28'd0, busy, done, ld_sel, 1'b0}, 32'b0010);
      check("rst_result", 32'(result), 32'd0);
      #12 rst_n = 1'b1;
      tick();

      // Load a nonzero result, then reset mid-run of (200,3)
      do_op(48, 18, "pre", -1);
      a_in = 8'd200; b_in = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("mid_busy", 32'(busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_outs", {29'd0, busy, done, ld_sel}, 32'b001);
      check("arst_result", 32'(result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad_done = 0;
      repeat (300) begin
         tick();
         if (done || busy) bad_done = 1;
      end
      check("no_done_after_rst", 32'(bad_done), 32'd0);

      // (48,18): register trace and latency
      do_op(48, 18, "t48_18", -1);
      check("t48_18_trace_len", 32'(trace.size()), 32'd5);
      if (trace.size() >= 5) begin
         check("t48_18_r0", 32'(trace[0]), {16'd0, 8'd48, 8'd18});
         check("t48_18_r1", 32'(trace[1]), {16'd0, 8'd30, 8'd18});
         check("t48_18_r2", 32'(trace[2]), {16'd0, 8'd12, 8'd18});
         check("t48_18_r3", 32'(trace[3]), {16'd0, 8'd12, 8'd6});
         check("t48_18_r4", 32'(trace[4]), {16'd0, 8'd6, 8'd6});
      end

      // Zero operands
      do_op(0, 35, "t0_35", -1);
      check("t0_35_lat", 32'(last_cycles), 32'd1);
      do_op(0, 0, "t0_0", -1);

      // Worst case
      do_op(255, 1, "t255_1", -1);
      check("t255_1_busy", 32'(last_busy), 32'd255);

      // Stray start during RUN is ignored
      do_op(48, 18, "ign", 2);
      check("ign_idle", 32'(busy), 32'd0);

      // Start held high: one operation every S+3 = 7 cycles
      a_in = 8'd48; b_in = 8'd18; start = 1'b1;
      pb = busy;
      for (int t = 1; t <= 13; t++) begin
         tick();
         if (t == 13) start = 1'b0;
         if (done) t_done.push_back(t);
         if (busy && !pb) t_busy_rise.push_back(t);
         pb = busy;
      end
      check("held_ndone", 32'(t_done.size()), 32'd2);
      check("held_nrise", 32'(t_busy_rise.size()), 32'd2);
      if (t_done.size() == 2 && t_busy_rise.size() == 2) begin
         check("held_done0", 32'(t_done[0]), 32'd6);
         check("held_done1", 32'(t_done[1]), 32'd13);
         check("held_rise1", 32'(t_busy_rise[1]), 32'd8);
      end
      tick();
      check("held_idle", {30'd0, busy, done}, 32'd0);

      // Random sweep
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom_range(0, 255);
         rb = $urandom_range(0, 255);
         if (($urandom & 15) == 0) rb = 0;
         do_op(ra, rb, "rnd", -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
